// File: rtl/always_assign_sync.sv
// Single-bit input conditioner: synchronizer chain, consecutive-cycle glitch
// filter, registered output with rise/fall pulses and a wrapping edge counter.
module always_assign_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

  // Declaration initializers give a defined power-up state when rst is tied low.
  logic [SYNC_STAGES-1:0] r_sync     = '0;
  logic [FCW-1:0]         r_filt_cnt = '0;
  logic                   r_out      = 1'b0;
  logic                   r_rise     = 1'b0;
  logic                   r_fall     = 1'b0;
  logic [CNT_W-1:0]       r_edge_cnt = '0;

  logic                   w_s;
  logic [FCW-1:0]         w_filt_cnt_next;
  logic                   w_out_next;
  logic                   w_rise_next;
  logic                   w_fall_next;
  logic [CNT_W-1:0]       w_edge_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) r_sync[gi] <= 1'b0;
          else     r_sync[gi] <= a;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) r_sync[gi] <= 1'b0;
          else     r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign w_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_filt_cnt_next = '0;
    w_out_next      = r_out;
    w_rise_next     = 1'b0;
    w_fall_next     = 1'b0;
    w_edge_cnt_next = r_edge_cnt;
    if (w_s != r_out) begin
      if (r_filt_cnt == FILT_LAST) begin
        // Input has disagreed for FILTER_LEN consecutive cycles: accept it.
        w_out_next      = w_s;
        w_rise_next     = w_s;
        w_fall_next     = ~w_s;
        w_edge_cnt_next = r_edge_cnt + 1'b1;
      end else begin
        w_filt_cnt_next = r_filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt_cnt <= '0;
      r_out      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      r_filt_cnt <= w_filt_cnt_next;
      r_out      <= w_out_next;
      r_rise     <= w_rise_next;
      r_fall     <= w_fall_next;
      r_edge_cnt <= w_edge_cnt_next;
    end
  end

  assign out        = r_out;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign edge_count = r_edge_cnt;

endmodule

// File: tb/tb_always_assign_sync.sv
// Randomized and directed bench for always_assign_sync; two instances
// (default parameters and SYNC_STAGES=1/FILTER_LEN=1) share the same stimulus.
module tb_always_assign_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;

  logic       out0, rise0, fall0;
  logic [7:0] cnt0;
  logic       out1, rise1, fall1;
  logic [7:0] cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_assign_sync #(.SYNC_STAGES(2), .FILTER_LEN(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .a(a),
    .out(out0), .rise(rise0), .fall(fall0), .edge_count(cnt0)
  );

  always_assign_sync #(.SYNC_STAGES(1), .FILTER_LEN(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .a(a),
    .out(out1), .rise(rise1), .fall(fall1), .edge_count(cnt1)
  );

  // Reference model: out flips once the delayed input has disagreed with it
  // on each of the last FILTER_LEN edges since reset.
  int   ss [2] = '{2, 1};
  int   fl [2] = '{4, 1};
  bit   a_hist[$];
  int   nrun = 0;
  logic       m_out [2] = '{1'b0, 1'b0};
  logic       m_rise[2] = '{1'b0, 1'b0};
  logic       m_fall[2] = '{1'b0, 1'b0};
  logic [7:0] m_cnt [2] = '{8'd0, 8'd0};

  function automatic logic [10:0] exp_vec(int i);
    return {m_out[i], m_rise[i], m_fall[i], m_cnt[i]};
  endfunction

  function automatic logic [10:0] dut_vec(int i);
    if (i == 0) return {out0, rise0, fall0, cnt0};
    return {out1, rise1, fall1, cnt1};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      a_hist.delete();
      nrun = 0;
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_cnt[i] = 8'd0;
      end
    end else begin
      a_hist.push_back(a);
      nrun++;
      for (int i = 0; i < 2; i++) begin
        bit flip;
        flip = (nrun >= fl[i]);
        for (int j = 0; j < fl[i]; j++) begin
          int idx;
          bit s;
          idx = nrun - 1 - j - ss[i];
          s   = (idx >= 0) ? a_hist[idx] : 1'b0;
          if (s == m_out[i]) flip = 1'b0;
        end
        m_rise[i] = flip && !m_out[i];
        m_fall[i] = flip && m_out[i];
        if (flip) begin
          m_out[i] = ~m_out[i];
          m_cnt[i] = m_cnt[i] + 8'd1;
        end
      end
    end
    #1;
  endtask

  task automatic test_powerup();
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (dut_vec(i) !== 11'd0) begin
        fails++;
        $display("FAIL powerup inst%0d: got %h want 000", i, dut_vec(i));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (dut_vec(i) !== 11'd0) begin
        fails++;
        $display("FAIL reset inst%0d: got %h want 000", i, dut_vec(i));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 500; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== 11'd0) begin
          fails++;
          $display("FAIL idle inst%0d cyc %0d: got %h want 000", i, c, dut_vec(i));
        end
      end
    end
  endtask

  task automatic test_rise_latency();
    int lat0 = 0, lat1 = 0, nrise0 = 0;
    a = 1'b1;
    for (int n = 1; n <= 500; n++) begin
      step();
      if (out0 === 1'b1 && lat0 == 0) lat0 = n;
      if (out1 === 1'b1 && lat1 == 0) lat1 = n;
      if (rise0 === 1'b1) nrise0++;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL rise_hold inst%0d cyc %0d: got %h want %h", i, n, dut_vec(i), exp_vec(i));
        end
      end
    end
    tests++;
    if (lat0 != 6) begin
      fails++; $display("FAIL latency_default: got %0d want 6", lat0);
    end
    tests++;
    if (lat1 != 2) begin
      fails++; $display("FAIL latency_f1s1: got %0d want 2", lat1);
    end
    tests++;
    if (nrise0 != 1 || cnt0 !== 8'd1 || out0 !== 1'b1) begin
      fails++;
      $display("FAIL rise_once: got rises=%0d cnt=%0d out=%b want 1 1 1", nrise0, cnt0, out0);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] cnt_before;
    a = 1'b0;
    repeat (20) step();
    cnt_before = cnt0;
    for (int c = 0; c < 23; c++) begin
      a = (c < 3) ? 1'b1 : 1'b0;
      step();
      tests++;
      if (out0 !== 1'b0 || rise0 !== 1'b0 || fall0 !== 1'b0 || cnt0 !== cnt_before) begin
        fails++;
        $display("FAIL glitch cyc %0d: got out=%b rise=%b fall=%b cnt=%0d want 0 0 0 %0d",
                 c, out0, rise0, fall0, cnt0, cnt_before);
      end
      tests++;
      if (dut_vec(1) !== exp_vec(1)) begin
        fails++;
        $display("FAIL glitch_f1 cyc %0d: got %h want %h", c, dut_vec(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_toggle();
    int last_pulse = 0; // 1 = rise seen last, 2 = fall seen last
    rst = 1'b1; a = 1'b0;
    step();
    rst = 1'b0;
    for (int t = 0; t < 300; t++) begin
      a = ~a;
      for (int c = 0; c < 20; c++) begin
        step();
        for (int i = 0; i < 2; i++) begin
          tests++;
          if (dut_vec(i) !== exp_vec(i)) begin
            fails++;
            $display("FAIL toggle inst%0d t=%0d c=%0d: got %h want %h", i, t, c, dut_vec(i), exp_vec(i));
          end
        end
        if (rise0 === 1'b1 || fall0 === 1'b1) begin
          tests++;
          if ((rise0 === 1'b1 && last_pulse == 1) || (fall0 === 1'b1 && last_pulse != 1)) begin
            fails++;
            $display("FAIL alternate t=%0d: got rise=%b fall=%b last=%0d", t, rise0, fall0, last_pulse);
          end
          last_pulse = (rise0 === 1'b1) ? 1 : 2;
        end
      end
    end
    tests++;
    if (cnt0 !== 8'd44 || cnt1 !== 8'd44) begin
      fails++;
      $display("FAIL wrap_count: got %0d/%0d want 44/44", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_mid();
    int lat = 0, nrise = 0;
    a = 1'b1;
    repeat (10) step();
    rst = 1'b1;
    step();
    tests++;
    if (out0 !== 1'b0 || cnt0 !== 8'd0 || rise0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got out=%b cnt=%0d rise=%b want 0 0 0", out0, cnt0, rise0);
    end
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (out0 === 1'b1 && lat == 0) lat = n;
      if (rise0 === 1'b1) nrise++;
    end
    tests++;
    if (lat != 6 || nrise != 1 || cnt0 !== 8'd1) begin
      fails++;
      $display("FAIL reset_recover: got lat=%0d rises=%0d cnt=%0d want 6 1 1", lat, nrise, cnt0);
    end
  endtask

  task automatic test_random();
    int run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        a   = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 8);
      end
      run--;
      rst = ($urandom_range(0, 199) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (dut_vec(i) !== exp_vec(i)) begin
          fails++;
          $display("FAIL random inst%0d cyc %0d: got %h want %h", i, c, dut_vec(i), exp_vec(i));
        end
      end
      tests++;
      if ((rise0 & fall0) !== 1'b0 || (rise1 & fall1) !== 1'b0) begin
        fails++;
        $display("FAIL exclusive cyc %0d: got %b%b/%b%b want no both-high", c, rise0, fall0, rise1, fall1);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_powerup();
    test_reset();
    test_idle();
    test_rise_latency();
    test_glitch();
    test_toggle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
